// File: rtl/userio_osd_cmd.sv
// OSD command decoder: turns SPI command/data bytes into OSD buffer writes, enable/config updates and status readback.
// Optional readback (command 8'h80) is built only when USERIO_OSD_CMD_READBACK_EN is defined.
module userio_osd_cmd #(
    parameter logic [7:0] VERSION = 8'h12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk7_en,
    input  logic        spi_vld,
    input  logic        spi_rx,
    input  logic        spi_cmd,
    input  logic [7:0]  spi_din,
    output logic [7:0]  spi_dout,
    output logic        buf_wr,
    output logic [10:0] buf_addr,
    output logic [7:0]  buf_wdat,
    output logic        osd_enable,
    output logic [7:0]  cfg,
    input  logic [7:0]  status_in
);

    typedef enum logic [2:0] {IDLE, WRLINE, WRCFG, RDBACK, IGNORE} state_t;

    state_t     state, state_nxt;
    logic       accept;
    logic [2:0] line;
    logic [7:0] col;
    logic       do_write, do_cfg, do_line, do_on, do_off;
`ifdef USERIO_OSD_CMD_READBACK_EN
    logic [1:0] rd_idx, rd_idx_nxt;
`endif

    assign accept = clk7_en & spi_rx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else if (clk7_en) begin
            state <= state_nxt;
        end
    end

    // A dropped chip-select outranks any byte arriving in the same cycle.
    always_comb begin
        state_nxt = state;
        do_write  = 1'b0;
        do_cfg    = 1'b0;
        do_line   = 1'b0;
        do_on     = 1'b0;
        do_off    = 1'b0;
`ifdef USERIO_OSD_CMD_READBACK_EN
        rd_idx_nxt = rd_idx;
`endif
        if (clk7_en && !spi_vld) begin
            state_nxt = IDLE;
`ifdef USERIO_OSD_CMD_READBACK_EN
            rd_idx_nxt = 2'd0;
`endif
        end else if (accept && spi_cmd) begin
            casez (spi_din)
                8'b0010_0???: begin do_line = 1'b1; state_nxt = WRLINE; end
                8'h40:        begin do_on   = 1'b1; state_nxt = IGNORE; end
                8'h41:        begin do_off  = 1'b1; state_nxt = IGNORE; end
                8'h50:        state_nxt = WRCFG;
`ifdef USERIO_OSD_CMD_READBACK_EN
                8'h80:        begin state_nxt = RDBACK; rd_idx_nxt = 2'd0; end
`endif
                default:      state_nxt = IGNORE;
            endcase
        end else if (accept) begin
            case (state)
                WRLINE: do_write = 1'b1;
                WRCFG:  begin do_cfg = 1'b1; state_nxt = IGNORE; end
`ifdef USERIO_OSD_CMD_READBACK_EN
                RDBACK: if (rd_idx != 2'd2) rd_idx_nxt = rd_idx + 2'd1;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_wr     <= 1'b0;
            buf_addr   <= 11'd0;
            buf_wdat   <= 8'h00;
            osd_enable <= 1'b0;
            cfg        <= 8'h00;
            line       <= 3'd0;
            col        <= 8'h00;
        end else if (clk7_en) begin
            buf_wr <= do_write;
            if (do_write) begin
                buf_addr <= {line, col};
                buf_wdat <= spi_din;
                col      <= col + 8'd1;
            end
            if (do_line) begin
                line <= spi_din[2:0];
                col  <= 8'h00;
            end
            if (do_on)  osd_enable <= 1'b1;
            if (do_off) osd_enable <= 1'b0;
            if (do_cfg) cfg <= spi_din;
        end
    end

`ifdef USERIO_OSD_CMD_READBACK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_idx <= 2'd0;
        end else if (clk7_en) begin
            rd_idx <= rd_idx_nxt;
        end
    end

    // Decoded straight from registered state so the byte is ready well before the next SPI boundary.
    always_comb begin
        spi_dout = 8'h00;
        if (state == RDBACK) begin
            case (rd_idx)
                2'd0:    spi_dout = status_in;
                2'd1:    spi_dout = VERSION;
                default: spi_dout = 8'h00;
            endcase
        end
    end
`else
    assign spi_dout = 8'h00;
`endif

endmodule

// File: tb/tb_userio_osd_cmd.sv
// Testbench for userio_osd_cmd: directed scenarios then randomized byte traffic checked against a transaction-level model.
module tb_userio_osd_cmd;

    localparam logic [7:0] VER = 8'h12;
`ifdef USERIO_OSD_CMD_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    localparam int M_IDLE = 0, M_LINE = 1, M_CFG = 2, M_RD = 3, M_IGN = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1, clk7_en = 1'b0, spi_vld = 1'b1, spi_rx = 1'b0, spi_cmd = 1'b0;
    logic [7:0]  spi_din = 8'h00, status_in = 8'h00;
    logic [7:0]  spi_dout, buf_wdat, cfg;
    logic        buf_wr, osd_enable;
    logic [10:0] buf_addr;

    always #5 clk = ~clk;

    userio_osd_cmd dut (
        .clk(clk), .reset(reset), .clk7_en(clk7_en), .spi_vld(spi_vld), .spi_rx(spi_rx),
        .spi_cmd(spi_cmd), .spi_din(spi_din), .spi_dout(spi_dout), .buf_wr(buf_wr),
        .buf_addr(buf_addr), .buf_wdat(buf_wdat), .osd_enable(osd_enable), .cfg(cfg),
        .status_in(status_in)
    );

    int total = 0, bad = 0;
    int wr_seen = 0, m_pushed = 0;
    logic [18:0] exp_q[$];
    int          m_mode = M_IDLE, m_idx = 0;
    logic [2:0]  m_line = 3'd0;
    logic [7:0]  m_col = 8'h00, m_cfg = 8'h00;
    logic        m_osd = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Transaction-level model: one call per clock edge, acting on what the bus offered at that edge.
    function automatic void model_edge(input logic rst, en, vld, rx, cmd, input logic [7:0] din);
        if (rst) begin
            m_mode = M_IDLE; m_idx = 0; m_line = 3'd0; m_col = 8'h00; m_cfg = 8'h00; m_osd = 1'b0;
            m_pushed -= exp_q.size();
            exp_q.delete();
            return;
        end
        if (!en) return;
        if (!vld) begin
            m_mode = M_IDLE; m_idx = 0;
            return;
        end
        if (!rx) return;
        if (cmd) begin
            if (din[7:3] == 5'b00100) begin m_line = din[2:0]; m_col = 8'h00; m_mode = M_LINE; end
            else if (din == 8'h40) begin m_osd = 1'b1; m_mode = M_IGN; end
            else if (din == 8'h41) begin m_osd = 1'b0; m_mode = M_IGN; end
            else if (din == 8'h50) m_mode = M_CFG;
            else if (din == 8'h80 && RB) begin m_mode = M_RD; m_idx = 0; end
            else m_mode = M_IGN;
        end else if (m_mode == M_LINE) begin
            exp_q.push_back({m_line, m_col, din});
            m_pushed++;
            m_col = m_col + 8'd1;
        end else if (m_mode == M_CFG) begin
            m_cfg = din; m_mode = M_IGN;
        end else if (m_mode == M_RD) begin
            m_idx = (m_idx >= 2) ? 2 : m_idx + 1;
        end
    endfunction

    function automatic logic [7:0] exp_dout();
        if (m_mode != M_RD) return 8'h00;
        if (m_idx == 0) return status_in;
        if (m_idx == 1) return VER;
        return 8'h00;
    endfunction

    task automatic cyc(input logic rst, en, vld, rx, cmd, input logic [7:0] din);
        logic [18:0] e;
        reset = rst; clk7_en = en; spi_vld = vld; spi_rx = rx; spi_cmd = cmd; spi_din = din;
        @(negedge clk);
        if (buf_wr && clk7_en) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_wr", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(buf_addr), 32'(e[18:8]));
                chk("wr_data", 32'(buf_wdat), 32'(e[7:0]));
            end
        end
        @(posedge clk);
        model_edge(rst, en, vld, rx, cmd, din);
        #1;
        chk("osd_enable", 32'(osd_enable), 32'(m_osd));
        chk("cfg", 32'(cfg), 32'(m_cfg));
        chk("spi_dout", 32'(spi_dout), 32'(exp_dout()));
    endtask

    task automatic send(input logic cmd, input logic [7:0] din);
        int   gap;
        logic en;
        gap = $urandom_range(0, 3);
        repeat (gap) begin
            en = 1'($urandom_range(0, 1));
            cyc(1'b0, en, 1'b1, en ? 1'b0 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
        end
        cyc(1'b0, 1'b1, 1'b1, 1'b1, cmd, din);
    endtask

    task automatic drain();
        repeat (3) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        chk("wr_count", 32'(wr_seen), 32'(m_pushed));
    endtask

    task automatic vld_drop();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    logic [7:0] cmds[8];
    int         r;

    initial begin
        cmds = '{8'h20, 8'h25, 8'h27, 8'h40, 8'h41, 8'h50, 8'h80, 8'h00};

        // reset without clock enable must still clear everything
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("rst_buf_wr", 32'(buf_wr), 32'd0);
        chk("rst_buf_addr", 32'(buf_addr), 32'd0);
        chk("rst_buf_wdat", 32'(buf_wdat), 32'd0);
        chk("rst_osd", 32'(osd_enable), 32'd0);
        chk("rst_cfg", 32'(cfg), 32'd0);
        chk("rst_dout", 32'(spi_dout), 32'd0);

        // line 3 writes
        send(1'b1, 8'h23); send(1'b0, 8'hAA); send(1'b0, 8'hBB);
        drain();

        // column wrap within line 0
        send(1'b1, 8'h20);
        for (int i = 0; i < 257; i++) send(1'b0, 8'($urandom));
        drain();

        // enable / disable / config
        send(1'b1, 8'h40);
        chk("osd_on", 32'(osd_enable), 32'd1);
        vld_drop();
        send(1'b1, 8'h41);
        chk("osd_off", 32'(osd_enable), 32'd0);
        send(1'b1, 8'h50); send(1'b0, 8'h5A); send(1'b0, 8'hFF);
        chk("cfg_5a", 32'(cfg), 32'h5A);
        drain();

        // status readback
        status_in = 8'h81;
        send(1'b1, 8'h80);
        repeat (3) send(1'b0, 8'($urandom));
        vld_drop();

        // chip-select drop wins over a coincident byte
        send(1'b1, 8'h21); send(1'b0, 8'h11);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h22);
        send(1'b0, 8'h33);
        drain();

        // reset on top of an accepted line byte
        send(1'b1, 8'h22); send(1'b0, 8'h44); send(1'b0, 8'h55);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h66);
        chk("rst_mid_buf_wr", 32'(buf_wr), 32'd0);
        chk("rst_mid_buf_addr", 32'(buf_addr), 32'd0);
        chk("rst_mid_buf_wdat", 32'(buf_wdat), 32'd0);
        drain();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            status_in = 8'($urandom);
            r = $urandom_range(0, 49);
            if (r == 0) begin
                cyc(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), 1'b0, 8'($urandom));
            end else if (r < 5) begin
                vld_drop();
            end else if (r < 18) begin
                r = $urandom_range(0, 7);
                send(1'b1, (r == 7) ? 8'($urandom) : cmds[r]);
            end else begin
                send(1'b0, 8'($urandom));
            end
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
